// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, baud indices, frame constants and the
// divisor function used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic [2:0] BAUD_300    = 3'd0;
  localparam logic [2:0] BAUD_1200   = 3'd1;
  localparam logic [2:0] BAUD_4800   = 3'd2;
  localparam logic [2:0] BAUD_9600   = 3'd3;
  localparam logic [2:0] BAUD_19200  = 3'd4;
  localparam logic [2:0] BAUD_38400  = 3'd5;
  localparam logic [2:0] BAUD_57600  = 3'd6;
  localparam logic [2:0] BAUD_115200 = 3'd7;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = 14;

  function automatic int unsigned baud_rate(input logic [2:0] idx);
    case (idx)
      BAUD_300:    return 300;
      BAUD_1200:   return 1200;
      BAUD_4800:   return 4800;
      BAUD_9600:   return 9600;
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      default:     return 115200;
    endcase
  endfunction

  // Rounded clocks per oversample tick: round(clk_freq / (16 * baud)).
  function automatic logic [TICK_W-1:0] baud_divisor(input int unsigned clk_freq,
                                                     input logic [2:0]  idx);
    int unsigned rate;
    rate = baud_rate(idx);
    return TICK_W'((clk_freq + (OVERSAMPLE / 2) * rate) / (OVERSAMPLE * rate));
  endfunction

endpackage

// File: rtl/baud_controller.sv
// 16x oversample tick generator. The divisor table is constant-folded from
// CLK_FREQ; clear restarts the count so a frame's first tick is a full period away.
module baud_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic [2:0] baud_select,
  output logic       tick
);

  logic [TICK_W-1:0] div_table [8];
  logic [TICK_W-1:0] cnt_q;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      div_table[i] = baud_divisor(CLK_FREQ, 3'(i));
    end
  end

  assign tick = (cnt_q == div_table[baud_select] - TICK_W'(1));

  always_ff @(posedge clock) begin
    if (reset || clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TICK_W'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8E1 asynchronous transmitter: start, 8 data bits LSB first, even parity, stop.
// Byte, parity and baud index are latched on acceptance so the frame is self-contained.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  input  logic [2:0] baud_select,
  output logic       TxD,
  output logic       Tx_BUSY
);

  tx_state_e  state_q;
  logic [7:0] shift_q;
  logic       parity_q;
  logic [2:0] baud_q;
  logic [2:0] bit_idx_q;
  logic [3:0] os_cnt_q;
  logic       txd_q;
  logic       busy_q;
  logic       tick;
  logic       accept;
  logic       bit_end;

  assign accept  = Tx_WR && Tx_EN && !busy_q;
  assign bit_end = tick && (os_cnt_q == 4'(OVERSAMPLE - 1));
  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;

  baud_controller #(
    .CLK_FREQ (CLK_FREQ)
  ) u_baud (
    .clock       (clock),
    .reset       (reset),
    .clear       (accept),
    .baud_select (baud_q),
    .tick        (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      os_cnt_q  <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else if (state_q == StIdle) begin
      if (accept) begin
        shift_q   <= Tx_DATA;
        parity_q  <= ^Tx_DATA;
        baud_q    <= baud_select;
        bit_idx_q <= '0;
        os_cnt_q  <= '0;
        txd_q     <= 1'b0;
        busy_q    <= 1'b1;
        state_q   <= StStart;
      end
    end else if (tick) begin
      os_cnt_q <= os_cnt_q + 4'd1;
      if (bit_end) begin
        unique case (state_q)
          StStart: begin
            txd_q   <= shift_q[0];
            state_q <= StData;
          end
          StData: begin
            if (bit_idx_q == 3'd7) begin
              txd_q   <= parity_q;
              state_q <= StParity;
            end else begin
              // Bit 0 of shift_q is on the line; the next bit sits at index 1.
              txd_q     <= shift_q[1];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
          StParity: begin
            txd_q   <= 1'b1;
            state_q <= StStop;
          end
          StStop: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: a table of single-byte frames followed by
// hand-written sequences for ignored strobes, back-to-back frames, reset and baud latching.
module tb_uart_transmitter;

  logic       clock = 1'b0;
  logic       reset;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic [2:0] baud_select;
  logic       TxD;
  logic       Tx_BUSY;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Clocks per oversample tick at 50 MHz, indexed by baud_select.
  int unsigned div_tab [8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};

  typedef struct {
    logic [7:0] data;
    logic [2:0] baud;
    logic       en;
    logic       accept;
  } vec_t;

  vec_t vecs [3];

  uart_transmitter #(
    .CLK_FREQ (50_000_000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .Tx_DATA     (Tx_DATA),
    .baud_select (baud_select),
    .TxD         (TxD),
    .Tx_BUSY     (Tx_BUSY)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called just after a negedge; the strobe is sampled on the following posedge.
  task automatic strobe(input logic [7:0] data, input logic [2:0] baud, input logic en);
    Tx_DATA     = data;
    baud_select = baud;
    Tx_EN       = en;
    Tx_WR       = 1'b1;
    @(negedge clock);
    Tx_WR   = 1'b0;
    Tx_DATA = ~data;
  endtask

  // Entered at the negedge right after acceptance; leaves at the first negedge with
  // Tx_BUSY low, checking every bit's level at its first and last clock.
  task automatic check_frame(input logic [7:0] data, input int unsigned div, input string tag);
    logic [10:0]  bits;
    int unsigned  p;
    p    = 16 * div;
    bits = {1'b1, ^data, data, 1'b0};
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("%s bit%0d first", tag, k), TxD, bits[k]);
      chk($sformatf("%s busy bit%0d", tag, k), Tx_BUSY, 1'b1);
      repeat (p - 1) @(negedge clock);
      chk($sformatf("%s bit%0d last", tag, k), TxD, bits[k]);
      @(negedge clock);
    end
    chk($sformatf("%s busy end", tag), Tx_BUSY, 1'b0);
    chk($sformatf("%s idle line", tag), TxD, 1'b1);
  endtask

  task automatic check_idle(input int unsigned n, input string tag);
    repeat (n) @(negedge clock);
    chk($sformatf("%s txd", tag), TxD, 1'b1);
    chk($sformatf("%s busy", tag), Tx_BUSY, 1'b0);
  endtask

  initial begin
    int t1;
    int t2;

    vecs[0] = '{data: 8'hA5, baud: 3'd7, en: 1'b1, accept: 1'b1};
    vecs[1] = '{data: 8'h07, baud: 3'd7, en: 1'b1, accept: 1'b1};
    vecs[2] = '{data: 8'hFF, baud: 3'd7, en: 1'b0, accept: 1'b0};

    reset       = 1'b1;
    Tx_EN       = 1'b0;
    Tx_WR       = 1'b0;
    Tx_DATA     = 8'h00;
    baud_select = 3'd7;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset txd", TxD, 1'b1);
    chk("reset busy", Tx_BUSY, 1'b0);

    foreach (vecs[i]) begin
      strobe(vecs[i].data, vecs[i].baud, vecs[i].en);
      if (vecs[i].accept) begin
        check_frame(vecs[i].data, div_tab[vecs[i].baud], $sformatf("vec%0d", i));
      end else begin
        chk($sformatf("vec%0d no start", i), TxD, 1'b1);
        check_idle(40, $sformatf("vec%0d ignored", i));
      end
      Tx_EN = 1'b1;
      @(negedge clock);
    end

    // Strobe 100 clocks into a frame is dropped; the back-to-back byte follows in the
    // first Tx_BUSY-low cycle, so start bits are one frame plus one idle clock apart.
    strobe(8'h3C, 3'd7, 1'b1);
    t1 = cyc;
    fork
      check_frame(8'h3C, 27, "b2b first");
      begin
        repeat (100) @(negedge clock);
        Tx_DATA = 8'hFF;
        Tx_WR   = 1'b1;
        @(negedge clock);
        Tx_WR = 1'b0;
      end
    join
    strobe(8'hC3, 3'd7, 1'b1);
    t2 = cyc;
    chk("b2b start spacing", 32'(t2 - t1), 32'(11 * 16 * 27 + 1));
    check_frame(8'hC3, 27, "b2b second");
    check_idle(500, "after b2b");

    // Reset mid-frame aborts it and nothing resumes afterwards.
    strobe(8'h96, 3'd7, 1'b1);
    repeat (1000) @(negedge clock);
    chk("pre-reset busy", Tx_BUSY, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk("abort txd", TxD, 1'b1);
    chk("abort busy", Tx_BUSY, 1'b0);
    reset = 1'b0;
    check_idle(500, "after abort");
    strobe(8'h5A, 3'd7, 1'b1);
    check_frame(8'h5A, 27, "post-reset");

    // Baud index is latched at acceptance; changing it mid-frame has no effect.
    @(negedge clock);
    strobe(8'h55, 3'd3, 1'b1);
    fork
      check_frame(8'h55, 326, "baud latch");
      begin
        repeat (50) @(negedge clock);
        baud_select = 3'd7;
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
